seg7_display_ctrl: RTL and testbench

//  Memory-mapped 8-digit multiplexed 7-segment display peripheral on the Nexys A7.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_hex_decoder.sv | 15 +
 rtl/seg7_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the memory-mapped 7-segment display peripheral:
//   register word offsets, CTRL field positions, reset constants and the
//   active-low hex-to-segment mapping.
//   Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg7_pkg;

  // Register word offsets on the 2-bit address bus
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  // CTRL field positions
  localparam int CTRL_MASK_LSB = 0;   // [7:0]  digit_mask
  localparam int CTRL_DP_LSB   = 8;   // [15:8] dp_mask, 1 = dot lit
  localparam int CTRL_EN_BIT   = 16;  // global enable

  // Only the implemented CTRL bits are writable; the rest read as zero
  localparam logic [31:0] CTRL_WMASK = 32'h0001_FFFF;
  localparam logic [31:0] CTRL_RESET = 32'h0001_00FF;

  // Dark output values (active-low)
  localparam logic [7:0] AN_OFF    = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex digit to segment pattern, {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder
//   Combinational hex nibble to active-low 7-segment pattern.
//   Ports:
//     nibble  in  4  hex digit value
//     seg     out 7  {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7seg(nibble);

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
//   Memory-mapped 8-digit multiplexed 7-segment display controller.
//   A 32-bit DATA register is shown as 8 hex digits; a prescaler defines
//   the per-digit slot and the first BLANK_CYCLES of each slot keep all
//   anodes off to avoid ghosting between adjacent digits.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     en, we, addr   bus select, write strobe, word offset (DATA/CTRL/STATUS)
//     wdata, rdata   write data, combinational read data
//     an, seg, dp    registered active-low anode, segment and dot drives
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [31:0]   data_q, data_d;
  logic [31:0]   ctrl_q, ctrl_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0]    nibble_s;
  logic [6:0]    dec_seg_s;
  logic [7:0]    digit_mask_s;
  logic [7:0]    dp_mask_s;
  logic          lit_s;

  assign digit_mask_s = ctrl_q[CTRL_MASK_LSB +: 8];
  assign dp_mask_s    = ctrl_q[CTRL_DP_LSB +: 8];
  assign nibble_s     = data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

  // Register file write path
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (en && we) begin
      case (addr)
        ADDR_DATA: data_d = wdata;
        ADDR_CTRL: ctrl_d = wdata & CTRL_WMASK;
        default: begin
          data_d = data_q;
          ctrl_d = ctrl_q;
        end
      endcase
    end else begin
      data_d = data_q;
      ctrl_d = ctrl_q;
    end
  end

  // Free-running slot prescaler and digit index; bus writes never disturb it
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
    end
  end

  // Next output drive, derived from the current scan state and registers
  always_comb begin
    lit_s = (presc_q >= BLANK_END) && digit_mask_s[idx_q] && ctrl_q[CTRL_EN_BIT];
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit_s) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = dec_seg_s;
      dp_d  = ~dp_mask_s[idx_q];
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  // Read mux: zero unless this is a selected read
  always_comb begin
    rdata = 32'h0;
    if (en && !we) begin
      case (addr)
        ADDR_DATA:   rdata = data_q;
        ADDR_CTRL:   rdata = ctrl_q;
        ADDR_STATUS: rdata = {29'h0, idx_q};
        default:     rdata = 32'h0;
      endcase
    end else begin
      rdata = 32'h0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 32'h0;
      ctrl_q  <= CTRL_RESET;
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl
//   Scoreboard bench: the driver pushes expected rdata and expected
//   registered outputs computed by a time-based reference model
//   (digit index and slot phase derived arithmetically from the cycle
//   count since reset); two monitors pop and compare.
module tb_seg7_display_ctrl;

  localparam int RD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_display_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t        out_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: registers plus cycles elapsed since reset release
  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  int          m_t;

  function automatic out_t model_out();
    out_t       o;
    int         idx;
    int         ps;
    logic [3:0] nib;
    logic       lit;
    idx = (m_t / RD) % 8;
    ps  = m_t % RD;
    lit = (ps >= BL) && m_ctrl[idx] && m_ctrl[16];
    nib = 4'(m_data >> (4 * idx));
    o.an  = 8'hFF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    if (lit) begin
      o.an[idx] = 1'b0;
      o.seg     = seg_tab[nib];
      o.dp      = ~m_ctrl[8 + idx];
    end
    return o;
  endfunction

  function automatic logic [31:0] model_rd(input logic e, input logic w, input logic [1:0] a);
    if (!(e && !w)) return 32'h0;
    case (a)
      2'd0:    return m_data;
      2'd1:    return m_ctrl;
      2'd2:    return 32'((m_t / RD) % 8);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs at the falling edge and record expectations
  task automatic cycle(input logic r, input logic e, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; en = e; we = w; addr = a; wdata = d;
    if (r) begin
      m_data = 32'h0;
      m_ctrl = 32'h0001_00FF;
      m_t    = 0;
    end
    rd_q.push_back(model_rd(e, w, a));
    if (r) begin
      out_q.push_back('{8'hFF, 7'h7F, 1'b1});
    end else begin
      out_q.push_back(model_out());
      if (e && w && a == 2'd0) m_data = d;
      if (e && w && a == 2'd1) m_ctrl = d & 32'h0001_FFFF;
      m_t++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
  endtask

  task automatic run_to_phase(input int phase, input int period);
    for (int i = 0; i < 200 && (m_t % period) != phase; i++) idle(1);
  endtask

  // Read-data monitor: combinational, sampled shortly after inputs change
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rd_q.size() > 0) check32("rdata", rdata, rd_q.pop_front());
    end
  end

  // Output monitor: registered outputs, sampled just after the rising edge
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        check32("an",  {24'h0, an},  {24'h0, e.an});
        check32("seg", {25'h0, seg}, {25'h0, e.seg});
        check32("dp",  {31'h0, dp},  {31'h0, e.dp});
      end
    end
  end

  initial begin
    m_data = 32'h0;
    m_ctrl = 32'h0001_00FF;
    m_t    = 0;

    // 1. reset, then idle with DATA=0
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
    idle(12);

    // 2. full scan of 89ABCDEF including index wrap
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 32'h89AB_CDEF);
    idle(70);

    // 3. digits 0 and 2 only, dot on digit 0
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 32'h0001_0105);
    idle(64);
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 32'h0);

    // 4. disable mid-slot, scan keeps running, then re-enable
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 32'h0001_00FF);
    run_to_phase(4, RD);
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_00FF);
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 32'h0001_00FF);
    idle(24);

    // 5. bus corner cases
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 32'h1234_5678);
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0000);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'd3, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int         k;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      d = $urandom;
      case (k)
        0: cycle(1'b0, 1'b1, 1'b1, 2'd0, d);
        1: cycle(1'b0, 1'b1, 1'b1, 2'd1, ($urandom_range(0, 3) != 0) ? (d | 32'h0001_0000) : d);
        2: cycle(1'b0, 1'b1, 1'b1, 2'($urandom_range(2, 3)), d);
        3: cycle(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), d);
        default: cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)), 32'h0);
      endcase
    end

    // 6. reset at index 5, prescaler 4 while that digit is lit
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 32'h1234_5678);
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 32'h0001_00FF);
    run_to_phase(5 * RD + 4, 8 * RD);
    check32("pre_reset_an", {24'h0, an}, 32'h0000_00DF);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
    #1;
    check32("reset_an",  {24'h0, an},  32'h0000_00FF);
    check32("reset_seg", {25'h0, seg}, 32'h0000_007F);
    check32("reset_dp",  {31'h0, dp},  32'h0000_0001);
    cycle(1'b1, 1'b1, 1'b0, 2'd2, 32'h0);
    idle(30);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (out_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: out_q=%0d rd_q=%0d left, required 0", out_q.size(), rd_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
